// File: rtl/capture_pkg.sv
// capture_pkg: token types and widths shared by the video capture stream.
package capture_pkg;
    localparam int TOK_W = 5;
    typedef enum logic [1:0] {
        TOK_PIX   = 2'b00,
        TOK_EOL   = 2'b01,
        TOK_SOF   = 2'b10,
        TOK_BLANK = 2'b11
    } tok_type_t;
    typedef struct packed {
        tok_type_t  typ;
        logic [2:0] rgb;
    } token_t;
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous token FIFO; a write while full succeeds only if a read frees a slot.
module capture_fifo
    import capture_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   wr,
    input  token_t din,
    input  logic   rd,
    output token_t dout,
    output logic   empty,
    output logic   full
);
    localparam int AW = $clog2(DEPTH);
    token_t mem [DEPTH];
    token_t last;
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_rd, do_wr;
    assign empty = cnt == '0;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    // Once drained, the output keeps showing the last token popped.
    assign dout  = empty ? last : mem[rp];
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            last <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) begin
                rp   <= rp + 1'b1;
                last <= mem[rp];
            end
            cnt <= cnt + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end
endmodule

// File: rtl/video_capture_stream.sv
// video_capture_stream: turns hsync/vsync/rgb raster into SOF/pixel/EOL tokens behind a FIFO.
// Define CAPTURE_BLANK_EN to also emit blank tokens for line-active samples outside the frame.
module video_capture_stream
    import capture_pkg::*;
#(
    parameter int PIX_DIV    = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [2:0]       rgb,
    output logic [TOK_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    frame_cnt,
    output logic [CW-1:0]    line_pix,
    output logic [CW-1:0]    frame_lines,
    output logic             overflow
);
    localparam int PW = $clog2(PIX_DIV);
    logic hs_q, vs_q, hs_d, vs_d, low_seen, armed;
    logic [2:0] rgb_q;
    logic [PW-1:0] ph, ph_now;
    logic [CW-1:0] pix_run, line_run;
    logic sof, eol, pix, blk, nv, sv, hold_v, wr_v, empty, full;
    token_t first, second, hold, wr_tok, dout;
    always_comb begin
        ph_now = (hs_q & ~hs_d) ? '0 : ph;
        // low_seen forces a genuine vsync 0->1 after reset before the first frame.
        sof = vs_q & ~vs_d & low_seen;
        eol = armed & hs_d & ~hs_q & vs_q;
        pix = (armed | sof) & (ph_now == '0) & hs_q & vs_q;
`ifdef CAPTURE_BLANK_EN
        blk = armed & (ph_now == '0) & hs_q & ~vs_q;
`else
        blk = 1'b0;
`endif
        nv = sof | eol | pix | blk;
        sv = sof & (eol | pix);
        first.typ  = sof ? TOK_SOF : eol ? TOK_EOL : pix ? TOK_PIX : TOK_BLANK;
        first.rgb  = (!sof && !eol && pix) ? rgb_q : 3'd0;
        second.typ = eol ? TOK_EOL : TOK_PIX;
        second.rgb = eol ? 3'd0 : rgb_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            {hs_q, vs_q, hs_d, vs_d, low_seen, armed} <= '0;
            rgb_q       <= '0;
            ph          <= '0;
            pix_run     <= '0;
            line_run    <= '0;
            frame_cnt   <= '0;
            line_pix    <= '0;
            frame_lines <= '0;
            overflow    <= 1'b0;
            hold_v      <= 1'b0;
            hold        <= '0;
            wr_v        <= 1'b0;
            wr_tok      <= '0;
        end else begin
            hs_q     <= hsync;
            vs_q     <= vsync;
            rgb_q    <= rgb;
            hs_d     <= hs_q;
            vs_d     <= vs_q;
            low_seen <= low_seen | ~vsync;
            armed    <= armed | sof;
            ph       <= (ph_now == PW'(PIX_DIV - 1)) ? '0 : ph_now + 1'b1;
            // A pending held token always goes first; the newest event then takes its place.
            wr_v   <= hold_v | nv;
            wr_tok <= hold_v ? hold : first;
            hold_v <= hold_v ? nv : sv;
            hold   <= hold_v ? first : second;
            if (sof) begin
                frame_cnt   <= frame_cnt + 1'b1;
                frame_lines <= line_run;
            end
            if (eol) line_pix <= pix_run;
            line_run <= sof ? '0 : eol ? line_run + 1'b1 : line_run;
            pix_run  <= eol ? '0 : pix ? pix_run + 1'b1 : pix_run;
            overflow <= overflow | (wr_v & full & ~(out_ready & out_valid));
        end
    end
    capture_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_v),
        .din   (wr_tok),
        .rd    (out_ready),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );
    assign out_valid = ~empty;
    assign out_data  = dout;
endmodule

// File: tb/tb_video_capture_stream.sv
// tb_video_capture_stream: directed raster sequences with random pixels/geometry/backpressure,
// checked against a token-list and counter model of the capture behaviour.
module tb_video_capture_stream;
    localparam int PD = 2;
    localparam int DEPTH = 16;
    localparam logic [4:0] T_SOF = 5'b10000;
    localparam logic [4:0] T_EOL = 5'b01000;
    localparam logic [4:0] T_BLK = 5'b11000;

    logic clk = 0, reset = 0, hsync = 0, vsync = 0, out_ready = 1;
    logic [2:0] rgb = 0;
    logic [4:0] out_data;
    logic out_valid, overflow;
    logic [15:0] frame_cnt, line_pix, frame_lines;

    video_capture_stream #(.PIX_DIV(PD), .FIFO_DEPTH(DEPTH), .CW(16)) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .line_pix(line_pix), .frame_lines(frame_lines),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0, errs = 0, cyc = 0;
    bit rnd_ready = 0;
    logic [4:0] rx[$], exq[$];
    int rx_cyc[$];
    int m_fc = 0, m_lp = 0, m_fl = 0, m_lines = 0;

    always @(posedge clk) cyc++;
    // A token is consumed at the coming edge when valid and ready are both high now.
    always @(negedge clk)
        if (reset && out_valid && out_ready) begin
            rx.push_back(out_data);
            rx_cyc.push_back(cyc);
        end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        int n = 0;
        while (rx.size() < exq.size() && n < 2000) begin
            step(1);
            n++;
        end
        chk({tag, " count"}, rx.size(), exq.size());
        for (int i = 0; i < exq.size() && i < rx.size(); i++)
            chk($sformatf("%s tok%0d", tag, i), rx[i], exq[i]);
        rx.delete();
        rx_cyc.delete();
        exq.delete();
    endtask

    task automatic frame(input int nl, input int np, input bit together, input int col);
        logic [2:0] c;
        if (!together) begin
            vsync = 1;
            step(3);
        end
        exq.push_back(T_SOF);
        m_fc++;
        m_fl = m_lines;
        m_lines = 0;
        for (int l = 0; l < nl; l++) begin
            vsync = 1;
            hsync = 1;
            for (int p = 0; p < np; p++) begin
                c = (col < 0) ? 3'($urandom_range(0, 7)) : col[2:0];
                rgb = c;
                exq.push_back({2'b00, c});
                step(PD);
            end
            hsync = 0;
            rgb = 0;
            exq.push_back(T_EOL);
            m_lp = np;
            m_lines++;
            step(4);
        end
        vsync = 0;
        step(4);
        chk("frame_cnt", frame_cnt, m_fc);
        chk("frame_lines", frame_lines, m_fl);
        chk("line_pix", line_pix, m_lp);
    endtask

    initial begin
        int gap;
        // Reset, then idle raster lines must stay silent
        step(5);
        reset = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("idle out_valid", out_valid, 0);
        end
        chk("idle frame_cnt", frame_cnt, 0);
        chk("idle line_pix", line_pix, 0);
        chk("idle frame_lines", frame_lines, 0);
        chk("idle overflow", overflow, 0);

        // Fixed 3x8 frame of colour 5
        frame(3, 8, 0, 5);
        check_stream("t2");

        // Random geometry, colours and backpressure
        rnd_ready = 1;
        for (int f = 0; f < 3; f++) begin
            frame($urandom_range(1, 4), $urandom_range(1, 12), 0, -1);
            check_stream("rand");
        end
        rnd_ready = 0;
        out_ready = 1;
        step(2);
        chk("rand overflow", overflow, 0);

        // vsync and hsync rise together
        frame(2, $urandom_range(2, 10), 1, -1);
        gap = (rx.size() >= 2) ? rx_cyc[1] - rx_cyc[0] : -1;
        chk("t3 sof-pix gap", gap, 1);
        chk("t3 overflow", overflow, 0);
        check_stream("t3");

        // Full FIFO drops the tail of a 20-pixel line
        out_ready = 0;
        frame(1, 20, 0, -1);
        chk("t4 overflow", overflow, 1);
        while (exq.size() > DEPTH) void'(exq.pop_back());
        out_ready = 1;
        check_stream("t4");

        // Reset mid-line with tokens queued
        out_ready = 0;
        vsync = 1;
        step(3);
        hsync = 1;
        rgb = 3;
        step(7);
        chk("t5 queued", out_valid, 1);
        reset = 0;
        step(1);
        chk("t5 out_valid", out_valid, 0);
        chk("t5 frame_cnt", frame_cnt, 0);
        chk("t5 line_pix", line_pix, 0);
        chk("t5 frame_lines", frame_lines, 0);
        chk("t5 overflow", overflow, 0);
        reset = 1;
        m_fc = 0; m_lp = 0; m_fl = 0; m_lines = 0;
        exq.delete();
        rx.delete();
        rx_cyc.delete();
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            hsync = 1;
            step(6);
            hsync = 0;
            step(4);
        end
        chk("t5 no tokens", rx.size(), 0);
        chk("t5 still frame_cnt", frame_cnt, 0);
        chk("t5 still line_pix", line_pix, 0);
        vsync = 0;
        step(3);
        frame(2, $urandom_range(3, 9), 0, -1);
        check_stream("t5 frame");

        // Line-active samples outside the frame
        hsync = 1;
        step(8);
        hsync = 0;
        step(10);
`ifdef CAPTURE_BLANK_EN
        repeat (4) exq.push_back(T_BLK);
`endif
        check_stream("t6 blank");
        chk("end overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
